// File: rtl/left_shifter_pipe_if.sv
// Request/result channels of the pipelined left shifter.
// The slave view belongs to the shifter; the master view belongs to the issuing logic.
interface left_shifter_pipe_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [4:0]       in_sha;
    logic             in_rot;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_sha, in_rot, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_sha, in_rot, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/left_shifter_pipe.sv
// Five-stage logarithmic 32-bit left shifter (logical or rotate) with valid/ready flow control.
// Stage k applies the 2^k step while loading; results leave S4 in acceptance order.
module left_shifter_pipe #(
    parameter int TAG_W = 4
) (
    input logic                clk,
    input logic                rst_n,
    left_shifter_pipe_if.slave bus
);

    // Only the sha bits a later stage still needs are carried forward.
    logic [4:0]       valid_q, valid_d;
    logic [31:0]      data_q [5];
    logic [31:0]      data_d [5];
    logic [TAG_W-1:0] tag_q  [5];
    logic [TAG_W-1:0] tag_d  [5];
    logic [3:0]       rot_q, rot_d;
    logic [4:1]       sha0_q, sha0_d;
    logic [4:2]       sha1_q, sha1_d;
    logic [4:3]       sha2_q, sha2_d;
    logic             sha3_q, sha3_d;

    logic ready0, ready1, ready2, ready3, ready4;

    function automatic logic [31:0] stepShift(
        input logic [31:0] d,
        input logic        doShift,
        input logic        rot,
        input logic [4:0]  amt
    );
        logic [63:0] wide;
        wide = {d, d} << amt;
        if (!doShift) begin
            return d;
        end
        return rot ? wide[63:32] : (d << amt);
    endfunction

    assign ready4 = !valid_q[4] || bus.out_ready;
    assign ready3 = !valid_q[3] || ready4;
    assign ready2 = !valid_q[2] || ready3;
    assign ready1 = !valid_q[1] || ready2;
    assign ready0 = !valid_q[0] || ready1;

    assign bus.in_ready  = ready0;
    assign bus.out_valid = valid_q[4];
    assign bus.out_data  = data_q[4];
    assign bus.out_tag   = tag_q[4];

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        rot_d   = rot_q;
        sha0_d  = sha0_q;
        sha1_d  = sha1_q;
        sha2_d  = sha2_q;
        sha3_d  = sha3_q;

        if (ready0) begin
            valid_d[0] = bus.in_valid;
            if (bus.in_valid) begin
                data_d[0] = stepShift(bus.in_data, bus.in_sha[0], bus.in_rot, 5'd1);
                sha0_d    = bus.in_sha[4:1];
                rot_d[0]  = bus.in_rot;
                tag_d[0]  = bus.in_tag;
            end
        end

        if (ready1) begin
            valid_d[1] = valid_q[0];
            if (valid_q[0]) begin
                data_d[1] = stepShift(data_q[0], sha0_q[1], rot_q[0], 5'd2);
                sha1_d    = sha0_q[4:2];
                rot_d[1]  = rot_q[0];
                tag_d[1]  = tag_q[0];
            end
        end

        if (ready2) begin
            valid_d[2] = valid_q[1];
            if (valid_q[1]) begin
                data_d[2] = stepShift(data_q[1], sha1_q[2], rot_q[1], 5'd4);
                sha2_d    = sha1_q[4:3];
                rot_d[2]  = rot_q[1];
                tag_d[2]  = tag_q[1];
            end
        end

        if (ready3) begin
            valid_d[3] = valid_q[2];
            if (valid_q[2]) begin
                data_d[3] = stepShift(data_q[2], sha2_q[3], rot_q[2], 5'd8);
                sha3_d    = sha2_q[4];
                rot_d[3]  = rot_q[2];
                tag_d[3]  = tag_q[2];
            end
        end

        // S4 needs neither sha nor rot afterwards, so only data and tag move on.
        if (ready4) begin
            valid_d[4] = valid_q[3];
            if (valid_q[3]) begin
                data_d[4] = stepShift(data_q[3], sha3_q, rot_q[3], 5'd16);
                tag_d[4]  = tag_q[3];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rot_q   <= '0;
            sha0_q  <= '0;
            sha1_q  <= '0;
            sha2_q  <= '0;
            sha3_q  <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            rot_q   <= rot_d;
            sha0_q  <= sha0_d;
            sha1_q  <= sha1_d;
            sha2_q  <= sha2_d;
            sha3_q  <= sha3_d;
        end
    end

endmodule

// File: tb/tb_left_shifter_pipe.sv
// Self-checking bench for left_shifter_pipe: vector table, streaming, backpressure,
// mid-stream reset and a random handshake soak, all checked through a scoreboard queue.
module tb_left_shifter_pipe;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        int          acceptCycle;
        bit          latCheck;
    } sbEntry_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  sha;
        logic        rot;
        logic [3:0]  tag;
        logic [31:0] expected;
    } vector_t;

    logic clk;
    logic rst_n;
    logic manualReady;
    logic randReady;
    bit   randomMode;
    bit   latCheckOn;
    int   cycleCount;
    int   checks;
    int   failures;
    sbEntry_t scoreboard[$];

    logic        stallPending;
    logic [31:0] heldData;
    logic [3:0]  heldTag;

    left_shifter_pipe_if #(.TAG_W(4)) bus ();

    left_shifter_pipe #(.TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign bus.out_ready = randomMode ? randReady : manualReady;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    always @(posedge clk) begin
        #1;
        randReady = 1'($urandom_range(0, 1));
    end

    function automatic logic [31:0] refShift(input logic [31:0] d, input logic [4:0] s, input logic r);
        logic [31:0] res;
        res = d;
        for (int i = 0; i < int'(s); i++) begin
            res = r ? {res[30:0], res[31]} : {res[30:0], 1'b0};
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", name, actual, expected, cycleCount);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] data, input logic [4:0] sha, input logic rot,
                                 input logic [3:0] tag, input logic [31:0] expected);
        sbEntry_t e;
        int waited;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_sha   = sha;
        bus.in_rot   = rot;
        bus.in_tag   = tag;
        waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
            bus.in_valid = 1'b0;
            return;
        end
        e.data        = expected;
        e.tag         = tag;
        e.acceptCycle = cycleCount + 1;
        e.latCheck    = latCheckOn;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input int maxCycles);
        int n;
        n = 0;
        while ((scoreboard.size() != 0 || bus.out_valid) && n < maxCycles) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (scoreboard.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d results still pending, expected 0", scoreboard.size());
        end
    endtask

    // Output side: every retired result must be the oldest outstanding one.
    always @(negedge clk) begin
        sbEntry_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (scoreboard.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_result: got data 0x%08h tag %0d, expected no output", bus.out_data, bus.out_tag);
            end else begin
                e = scoreboard.pop_front();
                checkOutput("out_data", bus.out_data, e.data);
                checkOutput("out_tag", 32'(bus.out_tag), 32'(e.tag));
                if (e.latCheck) begin
                    checkOutput("latency", 32'(cycleCount), 32'(e.acceptCycle + 4));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && stallPending) begin
            checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("stall_data", bus.out_data, heldData);
            checkOutput("stall_tag", 32'(bus.out_tag), 32'(heldTag));
        end
        stallPending = rst_n && bus.out_valid && !bus.out_ready;
        heldData     = bus.out_data;
        heldTag      = bus.out_tag;
    end

    initial begin
        vector_t vectors[10];
        logic [31:0] d;
        logic [4:0]  s;
        logic        r;

        vectors[0] = '{32'h00000001, 5'd31, 1'b0, 4'h1, 32'h80000000};
        vectors[1] = '{32'hFFFFFFFF, 5'd4,  1'b0, 4'h2, 32'hFFFFFFF0};
        vectors[2] = '{32'h80000001, 5'd1,  1'b1, 4'h3, 32'h00000003};
        vectors[3] = '{32'h12345678, 5'd8,  1'b1, 4'h4, 32'h34567812};
        vectors[4] = '{32'hDEADBEEF, 5'd0,  1'b0, 4'h5, 32'hDEADBEEF};
        vectors[5] = '{32'hCAFEF00D, 5'd0,  1'b1, 4'h6, 32'hCAFEF00D};
        vectors[6] = '{32'h80000001, 5'd1,  1'b0, 4'h7, 32'h00000002};
        vectors[7] = '{32'hF0000000, 5'd4,  1'b1, 4'h8, 32'h0000000F};
        vectors[8] = '{32'h12345678, 5'd16, 1'b0, 4'h9, 32'h56780000};
        vectors[9] = '{32'hA5A5A5A5, 5'd31, 1'b1, 4'hA, 32'hD2D2D2D2};

        checks       = 0;
        failures     = 0;
        cycleCount   = 0;
        randomMode   = 1'b0;
        latCheckOn   = 1'b0;
        stallPending = 1'b0;
        manualReady  = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_sha   = '0;
        bus.in_rot   = 1'b0;
        bus.in_tag   = '0;
        rst_n        = 1'b1;

        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_out_data", bus.out_data, 32'd0);
        checkOutput("reset_out_tag", 32'(bus.out_tag), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);

        $display("[TB] directed vectors");
        latCheckOn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vectors[i].data, vectors[i].sha, vectors[i].rot, vectors[i].tag, vectors[i].expected);
            bus.in_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        waitDrain(50);

        $display("[TB] streaming 32 back-to-back");
        for (int i = 0; i < 32; i++) begin
            d = $urandom;
            s = 5'(i);
            r = 1'(i % 2);
            applyStimulus(d, s, r, 4'(i), refShift(d, s, r));
        end
        bus.in_valid = 1'b0;
        waitDrain(50);
        latCheckOn = 1'b0;

        $display("[TB] backpressure");
        manualReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 32'h0F0F1234 + 32'(i * 32'h01010101);
            s = 5'(3 * i + 1);
            r = 1'(i % 2);
            applyStimulus(d, s, r, 4'(i + 3), refShift(d, s, r));
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("full_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("full_out_data", bus.out_data, scoreboard[0].data);
            @(negedge clk);
        end
        @(posedge clk);
        #1 manualReady = 1'b1;
        waitDrain(50);

        $display("[TB] reset with transactions in flight");
        manualReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = 32'h13579BDF ^ 32'(i);
            applyStimulus(d, 5'(i + 2), 1'b0, 4'(i + 9), refShift(d, 5'(i + 2), 1'b0));
        end
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midreset_out_data", bus.out_data, 32'd0);
        checkOutput("midreset_out_tag", 32'(bus.out_tag), 32'd0);
        scoreboard.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postreset_in_ready", 32'(bus.in_ready), 32'd1);
        manualReady = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("postreset_out_valid", 32'(bus.out_valid), 32'd0);

        $display("[TB] random handshake soak");
        randomMode = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            if (gap > 0) begin
                bus.in_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            r = 1'($urandom_range(0, 1));
            applyStimulus(d, s, r, 4'(n), refShift(d, s, r));
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        manualReady = 1'b1;
        randomMode  = 1'b0;
        waitDrain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/left_shifter_pipe.md
# left_shifter_pipe

Pipelined 32-bit logarithmic left shifter with valid/ready handshake. It complements the datapath's combinational right shifter by shifting the other way. It supports logical shift-left (zero fill) and rotate-left, with one 5-bit shift amount per transaction. It sits in the execute stage next to the ALU for multi-cycle shift ops. A per-transaction tag lets the issuing logic match results.

## Interface
- TAG_W, default 4: width of the opaque transaction tag carried alongside the data.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a shift request is presented.
- in_ready  output  1  the block can accept a request this cycle.
- in_data  input  32  operand to shift.
- in_sha  input  5  shift amount, 0..31.
- in_rot  input  1  0 = logical left (zero fill), 1 = rotate left.
- in_tag  input  TAG_W  tag; returned unchanged.
- out_valid  output  1  result is presented.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  32  shifted result.
- out_tag  output  TAG_W  tag of the presented result.

## Operation
- Five register stages, S0..S4. Stage k holds: valid bit, data, remaining sha bits, rot, tag.
- Stage k conditionally shifts by 2^k when sha bit k = 1. S0 applies the shift by 1 as the request is captured. Each later stage applies its shift while loading from the previous stage.
- Logical mode: the vacated low bits are 0. Rotate mode: the bits leaving bit 31 re-enter at bit 0.
- Result is data << sha (logical), or (data << sha) | (data >> (32-sha)) (rotate). No wider intermediate result is kept; bits above 31 are discarded.
- sha = 0 passes the data through unchanged in both modes.
- Outputs come straight from S4: out_valid = S4.valid, and out_data and out_tag are S4's registers.
- Per-stage advance rule: stage k can load when it is empty or when it is draining this cycle.
  - ready4 = !S4.valid || out_ready
  - ready_k = !Sk.valid || ready_(k+1)
  - in_ready = ready0
- Handshake: a transfer occurs on a rising edge where valid && ready.
  - When stage k loads and no transfer is coming from stage k-1 (or from the input, for S0), its valid bit clears.
  - A stage that cannot advance holds all of its fields.
- The producer may change in_* only after a transfer. The block does not require in_valid to stay asserted.
- Results leave in acceptance order; there is no reordering and nothing is dropped.
- Asynchronous reset: all valid bits, data, sha, rot and tag registers clear to 0 immediately.
  - Consequence: out_valid = 0, out_data = 0, out_tag = 0. in_ready = 1 once rst_n is high.
  - Reset in the middle of an operation discards every in-flight transaction. No partial result is ever presented.

## Timing
- Latency: a request accepted at edge t is on out_* after edge t+4, i.e. visible during the 5th cycle after it is presented.
- Throughput: one transaction per cycle while out_ready = 1.
- Capacity: five transactions. With out_ready held at 0, in_ready drops in the cycle after the fifth acceptance.
- out_ready reaches in_ready through a combinational path (the ready chain). in_ready has no combinational dependence on in_valid.
- Simultaneous events:
  - A full pipeline with out_ready = 1 accepts a new request in the same cycle it retires the oldest.
  - A bubble in Sk is filled while the downstream stages stall.
- The out_* fields are stable while out_valid = 1 and out_ready = 0.

## Test plan
- Logical: in_data=0x00000001, sha=31, rot=0 -> out_data=0x80000000. Also 0xFFFFFFFF, sha=4 -> 0xFFFFFFF0. Each result appears 4 edges after acceptance, with the matching tag.
- Rotate: 0x80000001, sha=1, rot=1 -> 0x00000003. Also 0x12345678, sha=8, rot=1 -> 0x34567812. sha=0 returns the input unchanged in both modes.
- Streaming: 32 back-to-back requests (sha=0..31, tags incrementing) with out_ready=1 -> 32 results on consecutive cycles, in order, each matching the reference model.
- Backpressure: hold out_ready=0 -> in_ready falls after 5 acceptances and out_data stays stable. Release out_ready -> all 5 results drain in order with no loss or duplication.
- Random out_ready toggling and random in_valid gaps over 1000 transactions -> every result matches the model, in order, and none is lost or duplicated.
- Assert rst_n low mid-stream with 3 transactions in flight -> out_valid=0 and out_data=0 immediately. After release, in_ready=1 and none of the old results ever appear.
